branch_pc_ctrl: RTL and testbench
=================================

// Module: branch_pc_ctrl
// PURPOSE
//  Owns the fetch PC and applies control-flow redirects decided in ID. Consumes the
//  branch-taken decision from the condition handler plus the ID-stage instruction fields.
//  Computes branch, jump and JR targets, updates the PC and drives the IF/ID flush.
//  Produces the link write for AL-type branches and holds a redirect that resolves during a stall.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  DELAY_SLOT  1              1: delay-slot instr executes (no flush); 0: flush IF/ID on redirect
//  CNT_W       16             width of saturating taken-redirect counter
// PORTS
//  clk            in   1      clock, all state on rising edge
//  reset          in   1      synchronous, active-high
//  stall          in   1      hazard stall; PC and pending state hold
//  id_pc          in   32     PC of instruction currently in ID
//  br_valid       in   1      ID instr is a conditional branch
//  cond_true      in   1      branch condition met (condition handler output)
//  jump           in   1      ID instr is J/JAL
//  jr             in   1      ID instr is JR/JALR
//  link_req       in   1      ID instr writes return address (BAL, BLTZAL, JAL, JALR)
//  imm16          in   16     branch offset, instruction[15:0]
//  jidx26         in   26     jump index, instruction[25:0]
//  rs_value       in   32     forwarded rs for JR
//  pc             out  32     current fetch address
//  if_id_reset    out  1      IF/ID flush, combinational, consumed at same edge
//  link_we        out  1      one-cycle link write strobe
//  link_addr      out  32     id_pc + 8
//  addr_err       out  1      one-cycle pulse: JR target misaligned
//  taken_cnt      out  CNT_W  number of redirects applied, saturating
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=RUN, pending cleared. link_we, addr_err and taken_cnt are 0.
//   if_id_reset=1 while reset is high. Reset overrides everything, including PENDING.
//  Targets, mod 2^32:
//   - BR  = id_pc + 4 + {sext(imm16),2'b00}
//   - J   = {(id_pc+4)[31:28], jidx26, 2'b00}
//   - JR  = {rs_value[31:2], 2'b00}
//  redirect = jr | jump | (br_valid & cond_true). Priority jr > jump > br.
//  States: RUN, PENDING.
//  RUN, !stall, redirect:
//   - pc <= target at the edge ending the cycle.
//   - if_id_reset = !DELAY_SLOT in the same cycle.
//   - taken_cnt++.
//  RUN, !stall, no redirect: pc <= pc + 4. 32'hFFFF_FFFC wraps to 0. if_id_reset = 0.
//  RUN, stall, redirect: pc holds; target latched into pend_tgt; -> PENDING.
//   link_we is NOT issued yet.
//  RUN, stall, no redirect: pc holds.
//  PENDING, stall: hold. All ID inputs are ignored, since flags may change while stalled.
//  PENDING, !stall:
//   - pc <= pend_tgt and if_id_reset = !DELAY_SLOT.
//   - taken_cnt++ and -> RUN.
//   - ID inputs ignored this cycle (same branch instr).
//  link_we: 1 for one cycle when link_req=1 and the instr resolves unstalled, taken or not.
//   This is the !stall cycle of RUN, or the PENDING exit cycle using the latched link_req.
//   link_addr = id_pc + 8, latched with pend_tgt in PENDING.
//  addr_err: pulses with a JR redirect whose rs_value[1:0] != 0. Redirect still applies (aligned).
//  Latency: redirect visible on pc one cycle after resolving; sequential path also 1 cycle.
//  taken_cnt saturates at all-ones, no wrap.
// TESTING
//  - Reset: hold reset 2 cycles -> pc=RESET_PC, if_id_reset=1, taken_cnt=0.
//    Release -> pc 0,4,8.
//  - BEQ taken: id_pc=0x100, imm16=0xFFFE, br_valid=1, cond_true=1 -> next pc=0xFC.
//    if_id_reset=!DELAY_SLOT, taken_cnt=1.
//  - JR misaligned: rs_value=0x2003, jr=1 -> pc=0x2000, addr_err pulse.
//    Same cycle jump=1 -> JR wins.
//  - Stall: BLTZAL taken, stall=1 for 3 cycles, cond_true drops in cycle 2.
//    -> pc holds, link_we=0 until stall drops.
//    Then pc=target, link_we=1, link_addr=id_pc+8.
//  - Wrap: pc=0xFFFF_FFFC, no redirect -> pc=0.
//    Reset asserted in PENDING -> pc=RESET_PC, no pending redirect applied.
//  - Saturation: CNT_W=2 with 5 redirects -> taken_cnt=3.

Source files
------------

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: owns the fetch PC and applies control-flow redirects
// resolved in ID (conditional branches, J/JAL, JR/JALR).
// A redirect that resolves while the pipeline is stalled is captured
// together with its link information. It is then applied on the first
// unstalled cycle.
// if_id_reset is combinational so the IF/ID register can consume it at the
// same edge that loads the new PC. link_we, link_addr and addr_err are
// registered and line up with the cycle in which pc shows the redirect target.
// dbg_state exposes the FSM state (0 = RUN, 1 = PENDING) for observation.
module branch_pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DELAY_SLOT = 1,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      id_pc,
    input  logic             br_valid,
    input  logic             cond_true,
    input  logic             jump,
    input  logic             jr,
    input  logic             link_req,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jidx26,
    input  logic [31:0]      rs_value,
    output logic [31:0]      pc,
    output logic             if_id_reset,
    output logic             link_we,
    output logic [31:0]      link_addr,
    output logic             addr_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             dbg_state
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // With a delay slot the instruction behind the branch executes, so no flush.
    localparam logic            FLUSH_ON_REDIRECT = (DELAY_SLOT == 0);
    localparam logic [CNT_W-1:0] CNT_MAX          = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [31:0] pend_tgt;
    logic        pend_link;
    logic [31:0] pend_link_addr;
    logic        pend_err;

    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] link_calc;
    logic        take_br;
    logic        redirect;
    logic        jr_misalign;
    logic [31:0] target;
    logic [CNT_W-1:0] cnt_next;

    assign dbg_state = state;

    // Target arithmetic for the instruction in ID; everything wraps mod 2^32.
    always_comb begin
        seq_pc      = id_pc + 32'd4;
        br_off      = {{14{imm16[15]}}, imm16, 2'b00};
        br_tgt      = seq_pc + br_off;
        j_tgt       = {seq_pc[31:28], jidx26, 2'b00};
        jr_tgt      = {rs_value[31:2], 2'b00};
        link_calc   = id_pc + 32'd8;
        take_br     = br_valid & cond_true;
        redirect    = jr | jump | take_br;
        jr_misalign = jr & (rs_value[1:0] != 2'b00);
        // JR beats J beats a taken branch.
        if (jr) begin
            target = jr_tgt;
        end else if (jump) begin
            target = j_tgt;
        end else begin
            target = br_tgt;
        end
        cnt_next = (taken_cnt == CNT_MAX) ? taken_cnt : taken_cnt + CNT_ONE;
    end

    // IF/ID flush: held during reset, otherwise raised in any cycle whose edge
    // loads a redirect target (fresh in RUN or replayed from PENDING).
    always_comb begin
        if_id_reset = 1'b0;
        if (reset) begin
            if_id_reset = 1'b1;
        end else if (!stall) begin
            if ((state == ST_RUN && redirect) || state == ST_PENDING) begin
                if_id_reset = FLUSH_ON_REDIRECT;
            end
        end
    end

    // PC / redirect FSM with registered side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            state          <= ST_RUN;
            pend_tgt       <= 32'd0;
            pend_link      <= 1'b0;
            pend_link_addr <= 32'd0;
            pend_err       <= 1'b0;
            link_we        <= 1'b0;
            link_addr      <= 32'd0;
            addr_err       <= 1'b0;
            taken_cnt      <= '0;
        end else begin
            link_we  <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (!stall) begin
                        if (redirect) begin
                            pc        <= target;
                            taken_cnt <= cnt_next;
                            addr_err  <= jr_misalign;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                        // Link is written whether or not the branch is taken.
                        if (link_req) begin
                            link_we   <= 1'b1;
                            link_addr <= link_calc;
                        end
                    end else if (redirect) begin
                        // Freeze the decision now: ID flags may change while stalled.
                        pend_tgt       <= target;
                        pend_link      <= link_req;
                        pend_link_addr <= link_calc;
                        pend_err       <= jr_misalign;
                        state          <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // ID inputs are ignored here; only the captured decision counts.
                    if (!stall) begin
                        pc        <= pend_tgt;
                        taken_cnt <= cnt_next;
                        addr_err  <= pend_err;
                        if (pend_link) begin
                            link_we   <= 1'b1;
                            link_addr <= pend_link_addr;
                        end
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// Bench for branch_pc_ctrl. Two instances share the stimulus:
// u_a uses the defaults (delay slot, 16-bit counter).
// u_b has no delay slot and a 2-bit counter, for flush and saturation.
module tb_branch_pc_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] id_pc;
    logic        br_valid;
    logic        cond_true;
    logic        jump;
    logic        jr;
    logic        link_req;
    logic [15:0] imm16;
    logic [25:0] jidx26;
    logic [31:0] rs_value;

    logic [31:0] pc_a, pc_b, la_a, la_b;
    logic        fl_a, fl_b, lwe_a, lwe_b, err_a, err_b, st_a, st_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        lwe;
        logic [31:0] la;
        logic        err;
        logic        st;
        logic [15:0] ca;
        logic [1:0]  cb;
    } exp_t;

    exp_t exp_q[$];

    branch_pc_ctrl u_a (
        .clk(clk), .reset(reset), .stall(stall), .id_pc(id_pc),
        .br_valid(br_valid), .cond_true(cond_true), .jump(jump), .jr(jr),
        .link_req(link_req), .imm16(imm16), .jidx26(jidx26), .rs_value(rs_value),
        .pc(pc_a), .if_id_reset(fl_a), .link_we(lwe_a), .link_addr(la_a),
        .addr_err(err_a), .taken_cnt(cnt_a), .dbg_state(st_a)
    );

    branch_pc_ctrl #(.DELAY_SLOT(0), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .id_pc(id_pc),
        .br_valid(br_valid), .cond_true(cond_true), .jump(jump), .jr(jr),
        .link_req(link_req), .imm16(imm16), .jidx26(jidx26), .rs_value(rs_value),
        .pc(pc_b), .if_id_reset(fl_b), .link_we(lwe_b), .link_addr(la_b),
        .addr_err(err_b), .taken_cnt(cnt_b), .dbg_state(st_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        id_pc     = 32'd0;
        br_valid  = 1'b0;
        cond_true = 1'b0;
        jump      = 1'b0;
        jr        = 1'b0;
        link_req  = 1'b0;
        imm16     = 16'd0;
        jidx26    = 26'd0;
        rs_value  = 32'd0;
    endtask

    // Inputs are already driven. Check the combinational flush before the edge,
    // queue the expected post-edge state, clock, then pop and compare.
    task automatic step(input string tag, input logic e_fa, input logic e_fb,
                        input logic [31:0] e_pc, input logic e_lwe,
                        input logic [31:0] e_la, input logic e_err, input logic e_st,
                        input logic [15:0] e_ca, input logic [1:0] e_cb);
        exp_t e;
        exp_q.push_back('{pc: e_pc, lwe: e_lwe, la: e_la, err: e_err, st: e_st,
                          ca: e_ca, cb: e_cb});
        #1;
        chk({tag, ".flush_a"}, {31'd0, fl_a}, {31'd0, e_fa});
        chk({tag, ".flush_b"}, {31'd0, fl_b}, {31'd0, e_fb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc_a"},   pc_a, e.pc);
        chk({tag, ".pc_b"},   pc_b, e.pc);
        chk({tag, ".lwe_a"},  {31'd0, lwe_a}, {31'd0, e.lwe});
        chk({tag, ".lwe_b"},  {31'd0, lwe_b}, {31'd0, e.lwe});
        chk({tag, ".la_a"},   la_a, e.la);
        chk({tag, ".err_a"},  {31'd0, err_a}, {31'd0, e.err});
        chk({tag, ".err_b"},  {31'd0, err_b}, {31'd0, e.err});
        chk({tag, ".st_a"},   {31'd0, st_a}, {31'd0, e.st});
        chk({tag, ".cnt_a"},  {16'd0, cnt_a}, {16'd0, e.ca});
        chk({tag, ".cnt_b"},  {30'd0, cnt_b}, {30'd0, e.cb});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #2;

        // Reset held two cycles
        step("rst1", 1, 1, 32'h0, 0, 32'h0, 0, 0, 16'd0, 2'd0);
        step("rst2", 1, 1, 32'h0, 0, 32'h0, 0, 0, 16'd0, 2'd0);
        reset = 1'b0;
        step("seq4", 0, 0, 32'h4, 0, 32'h0, 0, 0, 16'd0, 2'd0);
        step("seq8", 0, 0, 32'h8, 0, 32'h0, 0, 0, 16'd0, 2'd0);

        // BEQ taken, backward offset: 0x104 - 8 = 0xFC
        id_pc = 32'h100; imm16 = 16'hFFFE; br_valid = 1; cond_true = 1;
        step("beq", 0, 1, 32'hFC, 0, 32'h0, 0, 0, 16'd1, 2'd1);

        // Branch-and-link not taken: sequential pc, link still written
        idle_inputs();
        id_pc = 32'h200; br_valid = 1; cond_true = 0; link_req = 1; imm16 = 16'h0040;
        step("bal_nt", 0, 0, 32'h100, 1, 32'h208, 0, 0, 16'd1, 2'd1);

        // JAL: upper nibble from id_pc+4
        idle_inputs();
        id_pc = 32'h3000_0010; jump = 1; jidx26 = 26'h40; link_req = 1;
        step("jal", 0, 1, 32'h3000_0100, 1, 32'h3000_0018, 0, 0, 16'd2, 2'd2);

        // JR misaligned together with J: JR wins, target aligned, addr_err pulse
        idle_inputs();
        jr = 1; jump = 1; rs_value = 32'h2003; jidx26 = 26'h3FF_FFFF; id_pc = 32'h500;
        step("jr_mis", 0, 1, 32'h2000, 0, 32'h3000_0018, 1, 0, 16'd3, 2'd3);

        idle_inputs();
        step("after_jr", 0, 0, 32'h2004, 0, 32'h3000_0018, 0, 0, 16'd3, 2'd3);

        // BLTZAL taken under a 3-cycle stall; flags change while stalled
        id_pc = 32'h400; imm16 = 16'h0010; br_valid = 1; cond_true = 1; link_req = 1; stall = 1;
        step("stall1", 0, 0, 32'h2004, 0, 32'h3000_0018, 0, 1, 16'd3, 2'd3);
        cond_true = 0; link_req = 0;
        step("stall2", 0, 0, 32'h2004, 0, 32'h3000_0018, 0, 1, 16'd3, 2'd3);
        jr = 1; rs_value = 32'h0000_0009; jump = 1;
        step("stall3", 0, 0, 32'h2004, 0, 32'h3000_0018, 0, 1, 16'd3, 2'd3);
        // Release: ID flags are ignored, latched target/link applied
        stall = 0;
        step("stall_rel", 0, 1, 32'h444, 1, 32'h408, 0, 0, 16'd4, 2'd3);

        idle_inputs();
        step("post_rel", 0, 0, 32'h448, 0, 32'h408, 0, 0, 16'd4, 2'd3);

        // Stall without redirect: pc holds, stays in RUN
        stall = 1;
        step("stall_nr", 0, 0, 32'h448, 0, 32'h408, 0, 0, 16'd4, 2'd3);

        // Wrap: JR to 0xFFFF_FFFC then sequential to 0
        idle_inputs();
        jr = 1; rs_value = 32'hFFFF_FFFC;
        step("jr_top", 0, 1, 32'hFFFF_FFFC, 0, 32'h408, 0, 0, 16'd5, 2'd3);
        idle_inputs();
        step("wrap", 0, 0, 32'h0, 0, 32'h408, 0, 0, 16'd5, 2'd3);
        step("wrap4", 0, 0, 32'h4, 0, 32'h408, 0, 0, 16'd5, 2'd3);

        // Enter PENDING with a jump to 0x400, then reset clears it
        jump = 1; jidx26 = 26'h100; stall = 1;
        step("pend", 0, 0, 32'h4, 0, 32'h408, 0, 1, 16'd5, 2'd3);
        idle_inputs();
        reset = 1'b1;
        step("pend_rst", 1, 1, 32'h0, 0, 32'h0, 0, 0, 16'd0, 2'd0);
        reset = 1'b0;
        step("rst_rel4", 0, 0, 32'h4, 0, 32'h0, 0, 0, 16'd0, 2'd0);
        step("rst_rel8", 0, 0, 32'h8, 0, 32'h0, 0, 0, 16'd0, 2'd0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
